dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (`memoryFile`) between the CPU load/store path and a debug/loader port. It sits between the CPU datapath (ALU-out address, register-file store data) and the memory.
- Arbitration is round-robin, one access per cycle.
- The debug port can lock the memory for bursts, bounded by a starvation limit.
- The block raises `cpu_stall`, which the CPU uses to hold `pc` whenever a CPU access is deferred.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU load/store path and a debug/loader port.
// Optional stall statistics counter enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  // state    | meaning
  // OWN_IDLE | nobody was granted last cycle
  // OWN_CPU  | CPU was granted last cycle
  // OWN_DBG  | debug was granted last cycle without lock
  // OWN_LOCK | debug was granted last cycle holding dbg_lock
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2,
    OWN_LOCK = 2'd3
  } owner_t;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  owner_t            owner_q, owner_d;
  logic              last_dbg_q, last_dbg_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] wdata_hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_IDLE;
      last_dbg_q <= 1'b1;
      lock_cnt_q <= 8'd0;
    end else begin
      owner_q    <= owner_d;
      last_dbg_q <= last_dbg_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    owner_d    = OWN_IDLE;
    last_dbg_d = last_dbg_q;
    lock_cnt_d = 8'd0;

    if (reset) begin
      if (cpu_req && dbg_req) begin
        if (owner_q == OWN_LOCK) begin
          if (lock_cnt_q < MAX_LOCK_C) dbg_gnt = 1'b1;
          else                         cpu_gnt = 1'b1;
        end else if (last_dbg_q) begin
          cpu_gnt = 1'b1;
        end else begin
          dbg_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end

    if (cpu_gnt) begin
      owner_d    = OWN_CPU;
      last_dbg_d = 1'b0;
    end else if (dbg_gnt) begin
      owner_d    = dbg_lock ? OWN_LOCK : OWN_DBG;
      last_dbg_d = 1'b1;
    end

    // The grant that first takes the lock is not counted; only grants while already locked are.
    if ((owner_q == OWN_LOCK) && dbg_gnt && dbg_lock && cpu_req && (lock_cnt_q != 8'hFF))
      lock_cnt_d = lock_cnt_q + 8'd1;
    else if ((owner_q == OWN_LOCK) && dbg_gnt && dbg_lock && cpu_req)
      lock_cnt_d = lock_cnt_q;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_addr  = addr_hold_q;
    mem_wdata = wdata_hold_q;
    mem_we    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else if (cpu_gnt || dbg_gnt) begin
      addr_hold_q  <= mem_addr;
      wdata_hold_q <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
      if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_q <= 16'h0000;
    else if (cpu_stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural memory attached.
// Expected stall_cnt follows DMEM_ARB_STATS_EN when the bench is built with it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall;
  logic [15:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [15:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [15:0] stall_cnt;

  logic [15:0] mem [0:255] = '{default: 16'h0000};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic lock,
                         input logic [15:0] addr, input logic [15:0] wd);
    dbg_req = req; dbg_we = we; dbg_lock = lock; dbg_addr = addr; dbg_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  logic [15:0] exp_stall;

  initial begin
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    // Requests during reset must not be granted.
    #1 set_cpu(1'b1, 1'b1, 16'h0077, 16'h5555);
    @(negedge clk);
    check_eq("rst_cpu_gnt", cpu_gnt, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_cpu_rvalid", cpu_rvalid, 0);
    check_eq("rst_dbg_rdata", dbg_rdata, 0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    do_reset();

    // Single-port write then read
    set_cpu(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    check_eq("wr_cpu_gnt", cpu_gnt, 1);
    check_eq("wr_mem_we", mem_we, 1);
    check_eq("wr_mem_addr", mem_addr, 16'h0010);
    check_eq("wr_stall", cpu_stall, 0);
    next_cycle();
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check_eq("rd_cpu_gnt", cpu_gnt, 1);
    check_eq("rd_mem_we", mem_we, 0);
    check_eq("wr_no_rvalid", cpu_rvalid, 0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check_eq("rd_rvalid", cpu_rvalid, 1);
    check_eq("rd_rdata", cpu_rdata, 16'hBEEF);
    check_eq("idle_hold_addr", mem_addr, 16'h0010);
    check_eq("idle_mem_we", mem_we, 0);
    next_cycle();
    @(negedge clk);
    check_eq("rvalid_pulse", cpu_rvalid, 0);
    check_eq("rdata_hold", cpu_rdata, 16'hBEEF);

    // Preload words used later
    next_cycle();
    set_cpu(1'b1, 1'b1, 16'h0020, 16'h1111);
    next_cycle();
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b1, 1'b1, 1'b0, 16'h0030, 16'h2222);
    @(negedge clk);
    check_eq("dbg_wr_gnt", dbg_gnt, 1);
    next_cycle();
    set_dbg(1'b1, 1'b1, 1'b0, 16'h0040, 16'h1234);
    next_cycle();
    set_dbg(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Conflict fairness from reset: CPU wins first
    do_reset();
    set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
    set_dbg(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("fair_cpu_gnt%0d", i), cpu_gnt, (i % 2 == 0));
      check_eq($sformatf("fair_dbg_gnt%0d", i), dbg_gnt, (i % 2 == 1));
      check_eq($sformatf("fair_stall%0d", i), cpu_stall, (i % 2 == 1));
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check_eq("fair_dbg_rvalid", dbg_rvalid, 1);
    check_eq("fair_dbg_rdata", dbg_rdata, 16'h2222);
    check_eq("fair_cpu_rvalid", cpu_rvalid, 0);
    check_eq("fair_cpu_rdata", cpu_rdata, 16'h1111);

    // Lock starvation bound: prior CPU grant makes debug win the first conflict
    do_reset();
    set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
    next_cycle();
    set_dbg(1'b1, 1'b0, 1'b1, 16'h0030, 16'h0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check_eq($sformatf("lock_dbg_gnt%0d", c), dbg_gnt, (c <= 8 || c == 10));
      check_eq($sformatf("lock_cpu_gnt%0d", c), cpu_gnt, (c == 9));
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Cancelled CPU write while debug is locked, plus stall statistics
    do_reset();
    set_dbg(1'b1, 1'b0, 1'b1, 16'h0050, 16'h0);
    next_cycle();
    set_cpu(1'b1, 1'b1, 16'h0040, 16'hDEAD);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq($sformatf("cancel_cpu_gnt%0d", c), cpu_gnt, 0);
      check_eq($sformatf("cancel_stall%0d", c), cpu_stall, 1);
      check_eq($sformatf("cancel_mem_we%0d", c), mem_we, 0);
      check_eq($sformatf("cancel_mem_addr%0d", c), mem_addr, 16'h0050);
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check_eq("cancel_drop_we", mem_we, 0);
    next_cycle();
    set_dbg(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
`ifdef DMEM_ARB_STATS_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    @(negedge clk);
    check_eq("stall_cnt", stall_cnt, exp_stall);
    next_cycle();
    set_cpu(1'b1, 1'b0, 16'h0040, 16'h0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check_eq("cancel_word_rvalid", cpu_rvalid, 1);
    check_eq("cancel_word_kept", cpu_rdata, 16'h1234);

    // Asynchronous reset in the cycle after a granted debug read
    do_reset();
    set_dbg(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    @(negedge clk);
    check_eq("ar_dbg_gnt", dbg_gnt, 1);
    next_cycle();
    set_dbg(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_eq("ar_rvalid_pre", dbg_rvalid, 1);
    check_eq("ar_rdata_pre", dbg_rdata, 16'h2222);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_rvalid_rst", dbg_rvalid, 0);
    check_eq("ar_rdata_rst", dbg_rdata, 0);
    next_cycle();
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 16'h0020, 16'h0);
    set_dbg(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    @(negedge clk);
    check_eq("ar_first_cpu_gnt", cpu_gnt, 1);
    check_eq("ar_first_dbg_gnt", dbg_gnt, 0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
